regfile_wport_arbiter: RTL and testbench

//  Sequences the register file's single write port (we3/wa3/wd3) between two writers.
//   A = pipeline writeback, normally highest priority.
//   B = long-latency unit (multiply/load).

---
 rtl/regfile_wport_arbiter_if.sv | 38 +++
 rtl/regfile_wport_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle for the register-file write-port arbiter: two writer handshakes,
// reservation and hazard lookup, and the registered write port.
interface regfile_wport_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [3:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [3:0]  b_addr;
  logic [31:0] b_data;
  logic        rsv_valid;
  logic [3:0]  rsv_addr;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic        hazard;
  logic [14:0] pend;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        pc_drop;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output rsv_valid, rsv_addr, ra1, ra2,
    input  a_ready, b_ready, hazard, pend,
    input  we3, wa3, wd3, pc_drop
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  rsv_valid, rsv_addr, ra1, ra2,
    output a_ready, b_ready, hazard, pend,
    output we3, wa3, wd3, pc_drop
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the single register-file write port between writeback (A) and
// a long-latency unit (B), with a starvation guard and pending scoreboard.
module regfile_wport_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   reset,
  regfile_wport_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_A,
    FORCE_B
  } state_e;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [14:0] pend_q, pend_d;
  logic        we3_q, we3_d;
  logic [3:0]  wa3_q, wa3_d;
  logic [31:0] wd3_q, wd3_d;
  logic        pc_drop_q, pc_drop_d;

  logic        a_rdy, b_rdy;
  logic        a_xfer, b_xfer, b_wait;
  logic [3:0]  x_addr;
  logic [31:0] x_data;
  logic [15:0] pend_ext;
  logic        h1, h2;

  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (!reset) begin
      unique case (state_q)
        PRI_A: begin
          a_rdy = 1'b1;
          b_rdy = ~bus.a_valid;
        end
        FORCE_B: b_rdy = 1'b1;
        default: ;
      endcase
    end
  end

  assign a_xfer = bus.a_valid & a_rdy;
  assign b_xfer = bus.b_valid & b_rdy;
  assign b_wait = bus.b_valid & ~b_rdy;
  assign x_addr = a_xfer ? bus.a_addr : bus.b_addr;
  assign x_data = a_xfer ? bus.a_data : bus.b_data;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (b_xfer) begin
      wait_cnt_d = 4'd0;
    end else if (b_wait && wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    unique case (state_q)
      PRI_A: begin
        if (b_wait && wait_cnt_q == LIMIT_M1) begin
          state_d = FORCE_B;
        end
      end
      FORCE_B: begin
        if (b_xfer) begin
          state_d = PRI_A;
        end else if (!bus.b_valid) begin
          // B abandoned its request: fall back rather than lock out A
          state_d    = PRI_A;
          wait_cnt_d = 4'd0;
        end
      end
      default: state_d = PRI_A;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    if (b_xfer && bus.b_addr != 4'hF) begin
      pend_d[bus.b_addr] = 1'b0;
    end
    if (bus.rsv_valid && bus.rsv_addr != 4'hF) begin
      pend_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    we3_d     = 1'b0;
    wa3_d     = wa3_q;
    wd3_d     = wd3_q;
    pc_drop_d = 1'b0;
    if (a_xfer || b_xfer) begin
      if (x_addr == 4'hF) begin
        pc_drop_d = 1'b1;
      end else begin
        we3_d = 1'b1;
        wa3_d = x_addr;
        wd3_d = x_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= PRI_A;
      wait_cnt_q <= 4'd0;
      pend_q     <= 15'd0;
      we3_q      <= 1'b0;
      wa3_q      <= 4'd0;
      wd3_q      <= 32'd0;
      pc_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pend_q     <= pend_d;
      we3_q      <= we3_d;
      wa3_q      <= wa3_d;
      wd3_q      <= wd3_d;
      pc_drop_q  <= pc_drop_d;
    end
  end

  // In-flight write counts too: the file only commits at the next edge
  assign pend_ext = {1'b0, pend_q};
  assign h1 = (bus.ra1 != 4'hF) &&
              (pend_ext[bus.ra1] || (we3_q && wa3_q == bus.ra1));
  assign h2 = (bus.ra2 != 4'hF) &&
              (pend_ext[bus.ra2] || (we3_q && wa3_q == bus.ra2));

  assign bus.a_ready = a_rdy;
  assign bus.b_ready = b_rdy;
  assign bus.hazard  = h1 | h2;
  assign bus.pend    = pend_q;
  assign bus.we3     = we3_q;
  assign bus.wa3     = wa3_q;
  assign bus.wd3     = wd3_q;
  assign bus.pc_drop = pc_drop_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: vector table for arbitration and
// latency, plus sequences for starvation, scoreboard, r15 and reset.
module tb_regfile_wport_arbiter;

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [3:0]  ba;
    logic [31:0] bd;
    logic        rv;
    logic [3:0]  rsa;
    logic        ear;
    logic        ebr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pcd;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  logic [3:0]  last_wa;
  logic [31:0] last_wd;
  vec_t tbl[9];

  regfile_wport_arbiter_if bus();

  regfile_wport_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [3:0] aa,
                              input logic [31:0] ad, input logic bv,
                              input logic [3:0] ba, input logic [31:0] bd,
                              input logic rv, input logic [3:0] rsa,
                              input logic ear, input logic ebr);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.rv = rv; v.rsa = rsa;
    v.ear = ear; v.ebr = ebr;
    return v;
  endfunction

  // Entered at posedge+1; returns at the following posedge+1.
  task automatic cycle(input vec_t v);
    wr_t e;
    wr_t g;
    logic ax, bx;
    logic [3:0] ta;
    logic [31:0] td;
    bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
    bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
    bus.rsv_valid = v.rv; bus.rsv_addr = v.rsa;
    @(negedge clk);
    chk("a_ready", 32'(bus.a_ready), 32'(v.ear));
    chk("b_ready", 32'(bus.b_ready), 32'(v.ebr));
    ax = v.av & v.ear;
    bx = v.bv & v.ebr;
    ta = ax ? v.aa : v.ba;
    td = ax ? v.ad : v.bd;
    e.we = 1'b0; e.pcd = 1'b0; e.wa = last_wa; e.wd = last_wd;
    if (ax | bx) begin
      if (ta == 4'hF) begin
        e.pcd = 1'b1;
      end else begin
        e.we = 1'b1; e.wa = ta; e.wd = td;
        last_wa = ta; last_wd = td;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk("we3", 32'(bus.we3), 32'(g.we));
    chk("wa3", 32'(bus.wa3), 32'(g.wa));
    chk("wd3", bus.wd3, g.wd);
    chk("pc_drop", 32'(bus.pc_drop), 32'(g.pcd));
  endtask

  initial begin
    vec_t v;
    tbl[0] = mk(1, 4'd3,  32'hDEADBEEF, 0, 4'd0, 32'h0, 0, 4'd0, 1, 0);
    tbl[1] = mk(0, 4'd0,  32'h0,        0, 4'd0, 32'h0, 0, 4'd0, 1, 1);
    tbl[2] = mk(1, 4'hF,  32'h12345678, 0, 4'd0, 32'h0, 0, 4'd0, 1, 0);
    tbl[3] = mk(0, 4'd0,  32'h0,        0, 4'd0, 32'h0, 0, 4'd0, 1, 1);
    tbl[4] = mk(0, 4'd0,  32'h0, 1, 4'd6, 32'h000000B6, 0, 4'd0, 1, 1);
    tbl[5] = mk(1, 4'd1,  32'h000000A1, 1, 4'd2, 32'h000000B2, 0, 4'd0, 1, 0);
    tbl[6] = mk(0, 4'd0,  32'h0, 1, 4'd2, 32'h000000B2, 0, 4'd0, 1, 1);
    tbl[7] = mk(1, 4'd7,  32'h000000A7, 1, 4'd7, 32'h000000B7, 0, 4'd0, 1, 0);
    tbl[8] = mk(0, 4'd0,  32'h0, 1, 4'd7, 32'h000000B7, 0, 4'd0, 1, 1);

    reset = 1'b1;
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
    bus.rsv_valid = 0; bus.rsv_addr = 0;
    bus.ra1 = 4'hF; bus.ra2 = 4'hF;
    last_wa = 4'd0; last_wd = 32'd0;

    @(negedge clk);
    chk("rst a_ready", 32'(bus.a_ready), 32'd0);
    chk("rst b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst we3", 32'(bus.we3), 32'd0);
    chk("rst wa3", 32'(bus.wa3), 32'd0);
    chk("rst wd3", bus.wd3, 32'd0);
    chk("rst pc_drop", 32'(bus.pc_drop), 32'd0);
    chk("rst pend", 32'(bus.pend), 32'd0);
    chk("rst hazard", 32'(bus.hazard), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) cycle(tbl[i]);

    // starvation: A held busy, B refused 4 cycles then forced
    for (int k = 0; k < 10; k++) begin
      v = mk(1, 4'd1, 32'(k), (k <= 4), 4'd5, 32'h0000B005, 0, 4'd0,
             (k != 4), (k == 4));
      cycle(v);
    end

    // scoreboard and hazard
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 4'd9, 1, 1));
    chk("pend r9 set", 32'(bus.pend), 32'h0200);
    bus.ra1 = 4'd9;
    #1;
    chk("hazard pend", 32'(bus.hazard), 32'd1);
    cycle(mk(0, 0, 0, 1, 4'd9, 32'h00000099, 0, 4'd0, 1, 1));
    chk("pend r9 clr", 32'(bus.pend), 32'h0);
    chk("hazard inflight", 32'(bus.hazard), 32'd1);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1));
    chk("hazard gone", 32'(bus.hazard), 32'd0);
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 4'hF, 1, 1));
    chk("rsv r15", 32'(bus.pend), 32'h0);
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 4'd4, 1, 1));
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 4'd4, 1, 1));
    chk("rsv twice", 32'(bus.pend), 32'h0010);
    cycle(mk(0, 0, 0, 1, 4'd4, 32'h00000044, 1, 4'd4, 1, 1));
    chk("set wins", 32'(bus.pend), 32'h0010);
    bus.ra1 = 4'hF;
    bus.ra2 = 4'd4;
    cycle(mk(1, 4'd4, 32'h000000A4, 0, 0, 0, 0, 4'd0, 1, 0));
    chk("A keeps pend", 32'(bus.pend), 32'h0010);
    chk("hazard ra2", 32'(bus.hazard), 32'd1);
    cycle(mk(0, 0, 0, 1, 4'd4, 32'h00000045, 0, 4'd0, 1, 1));
    chk("pend r4 clr", 32'(bus.pend), 32'h0);
    bus.ra2 = 4'hF;
    #1;
    chk("hazard r15", 32'(bus.hazard), 32'd0);

    // reset right after an A transfer with pend=0x0104
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 4'd2, 1, 1));
    cycle(mk(0, 0, 0, 0, 0, 0, 1, 4'd8, 1, 1));
    chk("pend 0104", 32'(bus.pend), 32'h0104);
    cycle(mk(1, 4'd5, 32'h55555555, 0, 0, 0, 0, 4'd0, 1, 0));
    reset = 1'b1;
    bus.b_valid = 1'b1;
    @(negedge clk);
    chk("mid rst a_ready", 32'(bus.a_ready), 32'd0);
    chk("mid rst b_ready", 32'(bus.b_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid rst we3", 32'(bus.we3), 32'd0);
    chk("mid rst pend", 32'(bus.pend), 32'd0);
    reset = 1'b0;
    last_wa = 4'd0;
    last_wd = 32'd0;
    cycle(mk(1, 4'd3, 32'hCAFEF00D, 0, 0, 0, 0, 4'd0, 1, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 4'd0, 1, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
